// File: rtl/instr_issue_if.sv
// instr_issue_if: fetch-side push and decode-side issue handshake of instr_issue_unit.
interface instr_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  Opcode;
  logic [3:0]  Funct;
  modport master (output in_valid, in_instr, out_ready, input in_ready, out_valid, Opcode, Funct);
  modport slave  (input in_valid, in_instr, out_ready, output in_ready, out_valid, Opcode, Funct);
endinterface

// File: rtl/instr_issue_unit.sv
// instr_issue_unit: instruction FIFO issuing Opcode/Funct to decode and halting on illegal opcodes until flush.
// ISSUE_STATS_EN adds saturating per-class issue counters; without it the cnt_* outputs are tied to 0.
module instr_issue_unit #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  instr_issue_if.slave     bus,
  output logic             halted,
  output logic [CNT_W-1:0] cnt_r,
  output logic [CNT_W-1:0] cnt_ld,
  output logic [CNT_W-1:0] cnt_sd,
  output logic [CNT_W-1:0] cnt_beq
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [0:0] RUN = 1'b0, HALT = 1'b1;
  localparam logic [6:0] OP_R = 7'b0110011, OP_LD = 7'b0000011, OP_SD = 7'b0100011, OP_BEQ = 7'b1100011;
  logic [11:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] occ;
  logic [0:0] state;
  logic empty, full, push, pop, unused;
  logic [6:0] in_op;
  logic [11:0] head;
  assign in_op = bus.in_instr[6:0];
  assign empty = occ == '0;
  assign full = occ == (AW+1)'(DEPTH);
  assign head = mem[rp];
  assign bus.in_ready = !full && !flush;
  assign bus.out_valid = !empty && state == RUN;
  assign bus.Opcode = empty ? '0 : head[11:5];
  assign bus.Funct = empty ? '0 : head[4:1];
  assign halted = state == HALT;
  assign push = bus.in_valid && bus.in_ready;
  assign pop = bus.out_valid && bus.out_ready;
  assign unused = ^{bus.in_instr[31], bus.in_instr[29:15], bus.in_instr[11:7]};
  // entry layout: {opcode, funct, illegal}
  always_ff @(posedge clk)
    if (push) mem[wp] <= {in_op, bus.in_instr[30], bus.in_instr[14:12], !(in_op inside {OP_R, OP_LD, OP_SD, OP_BEQ})};
  always_ff @(posedge clk)
    if (reset || flush) begin
      wp <= '0;
      rp <= '0;
      occ <= '0;
      state <= RUN;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      if (push != pop) occ <= push ? occ + 1'b1 : occ - 1'b1;
      if (pop && head[0]) state <= HALT;
    end
`ifdef ISSUE_STATS_EN
  logic [CNT_W-1:0] cnt [4];
  logic [3:0] hit;
  // illegal entries never match a class opcode, so they count nowhere
  always_comb hit = (pop && !flush) ? {head[11:5] == OP_BEQ, head[11:5] == OP_SD, head[11:5] == OP_LD, head[11:5] == OP_R} : 4'b0;
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++) cnt[i] <= reset ? '0 : (hit[i] && cnt[i] != '1) ? cnt[i] + 1'b1 : cnt[i];
  assign cnt_r = cnt[0];
  assign cnt_ld = cnt[1];
  assign cnt_sd = cnt[2];
  assign cnt_beq = cnt[3];
`else
  assign cnt_r = '0;
  assign cnt_ld = '0;
  assign cnt_sd = '0;
  assign cnt_beq = '0;
`endif
endmodule
